// File: rtl/sa_way_hit_select.sv
// Tag-match and way-select lookup stage for the set-associative cache, registered outputs.
// Optional multi-hit detection is enabled by defining SA_WAY_MULTI_HIT_DETECT_EN.
module sa_way_hit_select #(
    parameter int WAYS            = 4,
    parameter int TAG_BITS        = 18,
    parameter int LINE_SIZE_BYTES = 64,
    parameter int OFFSET_BITS     = 6,
    parameter int DATA_WIDTH      = 32,
    localparam int LINE_BITS      = 8 * LINE_SIZE_BYTES,
    localparam int WAY_BITS       = $clog2(WAYS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_req,
    input  logic [TAG_BITS-1:0]       i_tag,
    input  logic [OFFSET_BITS-1:0]    i_offset,
    input  logic [WAYS*TAG_BITS-1:0]  i_way_tags,
    input  logic [WAYS-1:0]           i_way_valid,
    input  logic [WAYS*LINE_BITS-1:0] i_way_data,
    output logic                      o_valid,
    output logic                      o_hit,
    output logic [WAYS-1:0]           o_hit_vec,
    output logic [WAY_BITS-1:0]       o_hit_way,
    output logic [LINE_BITS-1:0]      o_line,
    output logic [DATA_WIDTH-1:0]     o_word,
    output logic                      o_multi_hit
);

    logic [WAYS-1:0]       hit_vec;
    logic [WAY_BITS-1:0]   hit_way;
    logic [LINE_BITS-1:0]  line;
    logic [DATA_WIDTH-1:0] word;

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = i_way_valid[w] && (i_way_tags[w*TAG_BITS +: TAG_BITS] == i_tag);
        end
    end

    // Descending scan so the lowest hitting way wins; a miss leaves 0.
    // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAY_BITS'(w);
        end
    end

    // AND-OR mux: a miss yields zero, a multi-hit yields the OR of the hit lines.
    always_comb begin
        line = '0;
        for (int w = 0; w < WAYS; w++) begin
            line = line | ({LINE_BITS{hit_vec[w]}} & i_way_data[w*LINE_BITS +: LINE_BITS]);
        end
    end

    // Bytes beyond the end of the line read as zero rather than wrapping.
    always_comb begin
        word = '0;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (int'(i_offset) + b < LINE_SIZE_BYTES) begin
                word[8*b +: 8] = line[8*(int'(i_offset) + b) +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid   <= 1'b0;
            o_hit     <= 1'b0;
            o_hit_vec <= '0;
            o_hit_way <= '0;
            o_line    <= '0;
            o_word    <= '0;
        end else begin
            o_valid <= i_req;
            if (i_req) begin
                o_hit     <= |hit_vec;
                o_hit_vec <= hit_vec;
                o_hit_way <= hit_way;
                o_line    <= line;
                o_word    <= word;
            end
        end
    end

`ifdef SA_WAY_MULTI_HIT_DETECT_EN
    logic [WAY_BITS:0] hit_cnt;

    always_comb begin
        hit_cnt = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_cnt = hit_cnt + (WAY_BITS + 1)'(hit_vec[w]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_multi_hit <= 1'b0;
        end else if (i_req) begin
            o_multi_hit <= (hit_cnt > (WAY_BITS + 1)'(1));
        end
    end
`else
    assign o_multi_hit = 1'b0;
`endif

endmodule

// File: tb/tb_sa_way_hit_select.sv
// Directed bench for sa_way_hit_select: reset, single hit, invalid match, offset edge, multi-hit, hold.
module tb_sa_way_hit_select;

    localparam int WAYS       = 4;
    localparam int TAG_BITS   = 18;
    localparam int LINE_BITS  = 512;
    localparam int DATA_WIDTH = 32;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      i_req = 1'b0;
    logic [TAG_BITS-1:0]       i_tag = '0;
    logic [5:0]                i_offset = '0;
    logic [WAYS*TAG_BITS-1:0]  i_way_tags = '0;
    logic [WAYS-1:0]           i_way_valid = '0;
    logic [WAYS*LINE_BITS-1:0] i_way_data = '0;
    logic                      o_valid;
    logic                      o_hit;
    logic [WAYS-1:0]           o_hit_vec;
    logic [1:0]                o_hit_way;
    logic [LINE_BITS-1:0]      o_line;
    logic [DATA_WIDTH-1:0]     o_word;
    logic                      o_multi_hit;

    int checks = 0;
    int errors = 0;

    localparam logic [TAG_BITS-1:0] TAG_A = 18'h01111;
    localparam logic [TAG_BITS-1:0] TAG_B = 18'h02222;
    localparam logic [TAG_BITS-1:0] TAG_C = 18'h03333;
    localparam logic [TAG_BITS-1:0] TAG_D = 18'h00444;
    localparam logic [TAG_BITS-1:0] TAG_X = 18'h2ABCD;

`ifdef SA_WAY_MULTI_HIT_DETECT_EN
    localparam logic MULTI_EXP = 1'b1;
`else
    localparam logic MULTI_EXP = 1'b0;
`endif

    sa_way_hit_select dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_tag      (i_tag),
        .i_offset   (i_offset),
        .i_way_tags (i_way_tags),
        .i_way_valid(i_way_valid),
        .i_way_data (i_way_data),
        .o_valid    (o_valid),
        .o_hit      (o_hit),
        .o_hit_vec  (o_hit_vec),
        .o_hit_way  (o_hit_way),
        .o_line     (o_line),
        .o_word     (o_word),
        .o_multi_hit(o_multi_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE_BITS-1:0] act, input logic [LINE_BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic valid, input logic hit, input logic [3:0] vec,
                             input logic [1:0] way, input logic [LINE_BITS-1:0] line,
                             input logic [31:0] word, input logic multi);
        check({tag, ".valid"}, LINE_BITS'(o_valid), LINE_BITS'(valid));
        check({tag, ".hit"},   LINE_BITS'(o_hit),   LINE_BITS'(hit));
        check({tag, ".vec"},   LINE_BITS'(o_hit_vec), LINE_BITS'(vec));
        check({tag, ".way"},   LINE_BITS'(o_hit_way), LINE_BITS'(way));
        check({tag, ".line"},  o_line, line);
        check({tag, ".word"},  LINE_BITS'(o_word), LINE_BITS'(word));
        check({tag, ".multi"}, LINE_BITS'(o_multi_hit), LINE_BITS'(multi));
    endtask

    function automatic logic [LINE_BITS-1:0] ramp_line();
        logic [LINE_BITS-1:0] l;
        for (int k = 0; k < 64; k++) l[8*k +: 8] = 8'(k);
        return l;
    endfunction

    function automatic logic [LINE_BITS-1:0] fill_line(input logic [7:0] b);
        return {64{b}};
    endfunction

    task automatic set_way(input int w, input logic [TAG_BITS-1:0] tag, input logic [LINE_BITS-1:0] data);
        i_way_tags[w*TAG_BITS +: TAG_BITS] = tag;
        i_way_data[w*LINE_BITS +: LINE_BITS] = data;
    endtask

    // Launches one request at the falling edge; returns 1 time unit after the capturing edge.
    task automatic pulse_req();
        @(negedge clk);
        i_req = 1'b1;
        @(posedge clk);
        #1;
        i_req = 1'b0;
    endtask

    task automatic setup_single_hit();
        set_way(0, TAG_A, fill_line(8'h11));
        set_way(1, TAG_B, fill_line(8'h22));
        set_way(2, TAG_C, ramp_line());
        set_way(3, TAG_D, fill_line(8'h44));
        i_way_valid = 4'b1111;
        i_tag       = TAG_C;
        i_offset    = 6'd4;
    endtask

    initial begin
        #12;
        check_all("reset", 1'b0, 1'b0, 4'b0000, 2'd0, '0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        setup_single_hit();
        pulse_req();
        check_all("single", 1'b1, 1'b1, 4'b0100, 2'd2, ramp_line(), 32'h07060504, 1'b0);

        // Hold: inputs change while i_req stays low; outputs must not move.
        set_way(2, TAG_D, fill_line(8'h99));
        i_tag       = TAG_B;
        i_offset    = 6'd17;
        i_way_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("hold%0d", c), 1'b0, 1'b1, 4'b0100, 2'd2, ramp_line(), 32'h07060504, 1'b0);
            i_tag = i_tag ^ 18'h00001;
        end

        setup_single_hit();
        i_way_valid = 4'b1011;
        pulse_req();
        check_all("invalid", 1'b1, 1'b0, 4'b0000, 2'd0, '0, 32'h0, 1'b0);

        set_way(0, TAG_A, ramp_line());
        i_way_valid = 4'b1111;
        i_tag       = TAG_A;
        i_offset    = 6'd62;
        pulse_req();
        check_all("off62", 1'b1, 1'b1, 4'b0001, 2'd0, ramp_line(), 32'h00003F3E, 1'b0);

        // Back-to-back: offsets 60 then 63, one result per cycle.
        @(negedge clk);
        i_offset = 6'd60;
        i_req    = 1'b1;
        @(posedge clk);
        #1;
        check("b2b0.word", LINE_BITS'(o_word), LINE_BITS'(32'h3F3E3D3C));
        check("b2b0.valid", LINE_BITS'(o_valid), LINE_BITS'(1'b1));
        i_offset = 6'd63;
        @(posedge clk);
        #1;
        i_req = 1'b0;
        check("b2b1.word", LINE_BITS'(o_word), LINE_BITS'(32'h0000003F));
        check("b2b1.valid", LINE_BITS'(o_valid), LINE_BITS'(1'b1));

        set_way(0, TAG_A, fill_line(8'h11));
        set_way(1, TAG_X, fill_line(8'h0F));
        set_way(2, TAG_C, fill_line(8'h33));
        set_way(3, TAG_X, fill_line(8'hF0));
        i_way_valid = 4'b1111;
        i_tag       = TAG_X;
        i_offset    = 6'd8;
        pulse_req();
        check_all("multi", 1'b1, 1'b1, 4'b1010, 2'd1, fill_line(8'hFF), 32'hFFFFFFFF, MULTI_EXP);

        // Asynchronous reset between edges while a result is being presented.
        setup_single_hit();
        @(negedge clk);
        i_req = 1'b1;
        @(posedge clk);
        #1;
        check("prerst.valid", LINE_BITS'(o_valid), LINE_BITS'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check_all("midrst", 1'b0, 1'b0, 4'b0000, 2'd0, '0, 32'h0, 1'b0);
        i_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst.valid", LINE_BITS'(o_valid), LINE_BITS'(1'b0));
        check("postrst.word", LINE_BITS'(o_word), LINE_BITS'(32'h0));

        pulse_req();
        check_all("recap", 1'b1, 1'b1, 4'b0100, 2'd2, ramp_line(), 32'h07060504, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
